ntt_output_serializer: RTL and testbench

// - Parallel-to-serial transmitter on the NTT output side. Captures one full

---
 rtl/ntt_output_serializer.sv | 116 +++++++++++
 tb/tb_ntt_output_serializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_output_serializer.sv
// rtl/ntt_output_serializer.sv - captures an NTT lane vector and streams it one coefficient per valid/ready beat
// Optional NTT_SER_PINGPONG_EN adds a pending buffer so back-to-back frames stream without drops.
module ntt_output_serializer #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE      = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cap_start,
  input  logic [DATA_WIDTH_PER_INPUT-1:0]     cap_data [INPUT_PER_CYCLE],
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH_PER_INPUT-1:0]     out_data,
  output logic [$clog2(INPUT_PER_CYCLE)-1:0]  out_idx,
  output logic                                out_last,
  output logic                                busy,
  output logic                                overflow
);

  localparam int IDX_W = $clog2(INPUT_PER_CYCLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_PER_CYCLE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                          state;
  logic [DATA_WIDTH_PER_INPUT-1:0] act_buf [INPUT_PER_CYCLE];
  logic                            hs;
  logic                            last_hs;
  logic [IDX_W-1:0]                nxt_idx;

  assign hs       = out_valid && out_ready;
  assign last_hs  = hs && (out_idx == LAST_IDX);
  assign nxt_idx  = out_idx + IDX_W'(1);
  assign out_last = out_valid && (out_idx == LAST_IDX);

`ifdef NTT_SER_PINGPONG_EN
  logic [DATA_WIDTH_PER_INPUT-1:0] pend_buf [INPUT_PER_CYCLE];
  logic                            pend_valid;

  assign busy = (state == STREAM) || pend_valid;
`else
  assign busy = (state == STREAM);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      overflow  <= 1'b0;
`ifdef NTT_SER_PINGPONG_EN
      pend_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cap_start) begin
            act_buf   <= cap_data;
            out_data  <= cap_data[0];
            out_idx   <= '0;
            out_valid <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (last_hs) begin
            // Active buffer frees this cycle: chain the next frame with no bubble.
`ifdef NTT_SER_PINGPONG_EN
            if (pend_valid) begin
              act_buf    <= pend_buf;
              out_data   <= pend_buf[0];
              out_idx    <= '0;
              pend_valid <= cap_start;
              if (cap_start) begin
                pend_buf <= cap_data;
              end
            end else
`endif
            if (cap_start) begin
              act_buf  <= cap_data;
              out_data <= cap_data[0];
              out_idx  <= '0;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_idx   <= '0;
            end
          end else begin
            if (hs) begin
              out_idx  <= nxt_idx;
              out_data <= act_buf[nxt_idx];
            end
            if (cap_start) begin
`ifdef NTT_SER_PINGPONG_EN
              if (!pend_valid) begin
                pend_buf   <= cap_data;
                pend_valid <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
`else
              overflow <= 1'b1;
`endif
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_output_serializer.sv
// tb/tb_ntt_output_serializer.sv - self-checking bench for ntt_output_serializer
module tb_ntt_output_serializer;

  localparam int W = 28;
  localparam int N = 64;
`ifdef NTT_SER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cap_start = 1'b0;
  logic [W-1:0]         cap_data [N];
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [W-1:0]         out_data;
  logic [$clog2(N)-1:0] out_idx;
  logic                 out_last;
  logic                 busy;
  logic                 overflow;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Model: flat queue of beats still owed to the sink, plus position in frame.
  logic [W-1:0] bq[$];
  int           m_idx = 0;
  bit           m_ovf = 1'b0;

  ntt_output_serializer #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(N)) dut (
    .clk(clk), .rst(rst), .cap_start(cap_start), .cap_data(cap_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      bq.delete();
      m_idx = 0;
      m_ovf = 1'b0;
    end else begin
      int held;
      if (bq.size() > 0 && out_ready) begin
        void'(bq.pop_front());
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      end
      held = (bq.size() + N - 1) / N;
      if (cap_start) begin
        if (held < CAP) begin
          for (int i = 0; i < N; i++) bq.push_back(cap_data[i]);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(bq.size() > 0));
      chk("busy", 32'(busy), 32'(bq.size() > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("out_idx", 32'(out_idx), 32'(m_idx));
      chk("out_last", 32'(out_last), 32'((bq.size() > 0) && (m_idx == N - 1)));
      if (bq.size() > 0) chk("out_data", 32'(out_data), 32'(bq[0]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) cap_data[i] = base + W'(i);
  endtask

  task automatic cap(input logic [W-1:0] base);
    set_frame(base);
    cap_start = 1'b1;
    cyc();
    cap_start = 1'b0;
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    while (!(out_valid && 32'(out_idx) == target) && n < 300) begin
      cyc();
      n++;
    end
    chk("wait_idx_timeout", 32'(n < 300), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      cyc();
      n++;
    end
    chk("wait_idle_timeout", 32'(n < 400), 32'd1);
  endtask

  initial begin
    int hsn;
    int nv;
    set_frame(28'h0);
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    cyc();

    // Continuous streaming, first beat one cycle after capture.
    out_ready = 1'b1;
    cap(28'h100);
    for (int k = 0; k < N; k++) begin
      chk("t1_data", 32'(out_data), 32'h100 + 32'(k));
      chk("t1_last", 32'(out_last), 32'(k == 63));
      cyc();
    end
    chk("t1_end_valid", 32'(out_valid), 32'd0);
    chk("t1_end_busy", 32'(busy), 32'd0);

    // Backpressure pattern 1,0,0,1.
    cap(28'h100);
    hsn = 0;
    for (int k = 0; k < 400 && busy; k++) begin
      out_ready = (k % 4 == 0 || k % 4 == 3);
      if (out_valid && out_ready) hsn++;
      cyc();
    end
    chk("t2_handshakes", 32'(hsn), 32'd64);
    chk("t2_idle", 32'(busy), 32'd0);
    out_ready = 1'b1;

    // Capture on the last-beat handshake cycle.
    cap(28'h100);
    wait_idx(63);
    cap(28'h200);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_idx", 32'(out_idx), 32'd0);
    chk("t3_data", 32'(out_data), 32'h200);
    chk("t3_ovf", 32'(overflow), 32'd0);
    wait_idle();

    // Capture mid-frame, then another while the pending slot is full.
    cap(28'h100);
    wait_idx(10);
    cap(28'h200);
    wait_idx(20);
`ifdef NTT_SER_PINGPONG_EN
    chk("t4_ovf_mid", 32'(overflow), 32'd0);
`else
    chk("t4_ovf_mid", 32'(overflow), 32'd1);
`endif
    cap(28'h300);
    chk("t4_ovf_after", 32'(overflow), 32'd1);
    wait_idx(63);
    cyc();
`ifdef NTT_SER_PINGPONG_EN
    chk("t4_f2_valid", 32'(out_valid), 32'd1);
    chk("t4_f2_data", 32'(out_data), 32'h200);
`else
    chk("t4_f1_done", 32'(out_valid), 32'd0);
`endif
    wait_idle();

    // Reset mid-frame.
    cap(28'h100);
    wait_idx(30);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_idx", 32'(out_idx), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    cyc();
    cap(28'h400);
    chk("t5_fresh_data", 32'(out_data), 32'h400);
    chk("t5_fresh_idx", 32'(out_idx), 32'd0);
    wait_idle();

    // Changing cap_data without a strobe never produces beats.
    nv = 0;
    for (int k = 0; k < 50; k++) begin
      for (int i = 0; i < N; i++) cap_data[i] = W'($urandom);
      out_ready = 1'($urandom);
      cyc();
      if (out_valid) nv++;
    end
    chk("t6_no_valid", 32'(nv), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
